// File: rtl/step_fir_interp.sv
// step_fir_interp: 2x polyphase interpolator built on a symmetric 11-tap prototype.
// Each accepted input sample produces two outputs: the even phase, then the odd phase.
// Each sample passes through a pre-add stage, a multiply stage and a sum stage.
// The output handshake applies backpressure for as long as the consumer holds it off.
//
// Ports:
//   pClk        sole clock; all state changes on its rising edge
//   pRst        synchronous active-high reset
//   pInValid    input sample offered
//   pInReady    block accepts a sample this cycle (registered, high only in IDLE)
//   pFilterIn   signed 16-bit input sample
//   pOutValid   pFilterOut holds a valid output (registered)
//   pOutReady   downstream accepts the output sample
//   pFilterOut  signed 16-bit interpolated output (registered)
//
// Configuration:
//   STEP_FIR_INTERP_ROUND_EN  when defined, rounds half up before the >>16.
//                             When undefined, the result is truncated (floor).
module step_fir_interp (
  input  logic        pClk,
  input  logic        pRst,
  input  logic        pInValid,
  output logic        pInReady,
  input  logic [15:0] pFilterIn,
  output logic        pOutValid,
  input  logic        pOutReady,
  output logic [15:0] pFilterOut
);

  localparam int unsigned DW = 16;  // sample width
  localparam int unsigned PW = 17;  // pre-add width
  localparam int unsigned XW = 31;  // multiplier operand width
  localparam int unsigned MW = 30;  // product width
  localparam int unsigned SW = 32;  // phase sum width
  localparam int unsigned NH = 6;   // history depth

  localparam logic signed [XW-1:0] C1 = 31'sd5725;
  localparam logic signed [XW-1:0] C2 = 31'sd5864;
  localparam logic signed [XW-1:0] C3 = 31'sd5972;
  localparam logic signed [XW-1:0] C4 = 31'sd6051;
  localparam logic signed [XW-1:0] C5 = 31'sd6098;
  localparam logic signed [XW-1:0] C6 = 31'sd6114;

`ifdef STEP_FIR_INTERP_ROUND_EN
  localparam logic signed [SW-1:0] RND = 32'sd32768;
`else
  localparam logic signed [SW-1:0] RND = 32'sd0;
`endif

  typedef enum logic [2:0] {IDLE, PREADD, MULT, SUM, OUT_EVEN, OUT_ODD} state_t;

  state_t state, state_next;

  logic signed [DW-1:0] hist   [NH];
  logic signed [PW-1:0] pre_e  [3];
  logic signed [PW-1:0] pre_o  [3];
  logic signed [MW-1:0] prod_e [3];
  logic signed [MW-1:0] prod_o [3];
  logic signed [DW-1:0] res_e, res_o;
  logic signed [SW-1:0] sum_e_d, sum_o_d;
  logic signed [DW-1:0] res_e_d, res_o_d;
  logic                 in_xfer;

  assign in_xfer = pInValid & pInReady;

  // Phase sums with optional rounding offset; the arithmetic shift gives floor
  always_comb begin
    sum_e_d = SW'(prod_e[0]) + SW'(prod_e[1]) + SW'(prod_e[2]) + RND;
    sum_o_d = SW'(prod_o[0]) + SW'(prod_o[1]) + SW'(prod_o[2]) + RND;
    res_e_d = DW'(sum_e_d >>> 16);
    res_o_d = DW'(sum_o_d >>> 16);
  end

  // State register
  always_ff @(posedge pClk) begin
    if (pRst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (in_xfer) state_next = PREADD;
      PREADD:   state_next = MULT;
      MULT:     state_next = SUM;
      SUM:      state_next = OUT_EVEN;
      OUT_EVEN: if (pOutReady) state_next = OUT_ODD;
      OUT_ODD:  if (pOutReady) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // History, pipeline stages and registered handshake outputs
  always_ff @(posedge pClk) begin
    if (pRst) begin
      for (int i = 0; i < int'(NH); i++) hist[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        pre_e[i]  <= '0;
        pre_o[i]  <= '0;
        prod_e[i] <= '0;
        prod_o[i] <= '0;
      end
      res_e      <= '0;
      res_o      <= '0;
      pInReady   <= 1'b1;
      pOutValid  <= 1'b0;
      pFilterOut <= '0;
    end else begin
      if (in_xfer) begin
        hist[0] <= pFilterIn;
        for (int i = 1; i < int'(NH); i++) hist[i] <= hist[i-1];
      end

      // Symmetric taps folded before multiplication
      if (state == PREADD) begin
        pre_e[0] <= PW'(hist[0]) + PW'(hist[5]);
        pre_e[1] <= PW'(hist[1]) + PW'(hist[4]);
        pre_e[2] <= PW'(hist[2]) + PW'(hist[3]);
        pre_o[0] <= PW'(hist[0]) + PW'(hist[4]);
        pre_o[1] <= PW'(hist[1]) + PW'(hist[3]);
        pre_o[2] <= PW'(hist[2]);
      end

      if (state == MULT) begin
        prod_e[0] <= MW'(XW'(pre_e[0]) * C1);
        prod_e[1] <= MW'(XW'(pre_e[1]) * C3);
        prod_e[2] <= MW'(XW'(pre_e[2]) * C5);
        prod_o[0] <= MW'(XW'(pre_o[0]) * C2);
        prod_o[1] <= MW'(XW'(pre_o[1]) * C4);
        prod_o[2] <= MW'(XW'(pre_o[2]) * C6);
      end

      if (state == SUM) begin
        res_e <= res_e_d;
        res_o <= res_o_d;
      end

      pInReady  <= (state_next == IDLE);
      pOutValid <= (state_next == OUT_EVEN) || (state_next == OUT_ODD);

      // Even result is loaded straight from the adder so it appears on entry to OUT_EVEN
      if (state == SUM)
        pFilterOut <= res_e_d;
      else if (state == OUT_EVEN)
        pFilterOut <= pOutReady ? res_o : res_e;
    end
  end

endmodule

// File: tb/tb_step_fir_interp.sv
// Self-checking bench for step_fir_interp: impulse/DC vector table, latency,
// backpressure, mid-operation reset and randomized traffic against a reference model.
module tb_step_fir_interp;

  logic        pClk = 1'b0;
  logic        pRst;
  logic        pInValid;
  logic        pInReady;
  logic [15:0] pFilterIn;
  logic        pOutValid;
  logic        pOutReady;
  logic [15:0] pFilterOut;

  int n_checks = 0;
  int n_fail   = 0;
  int hist [6];

  typedef struct {
    bit rst;
    int din;
    bit chk;
    int ev;
    int od;
  } vec_t;

  vec_t vecs [22];

  always #5 pClk = ~pClk;

  step_fir_interp dut (
    .pClk       (pClk),
    .pRst       (pRst),
    .pInValid   (pInValid),
    .pInReady   (pInReady),
    .pFilterIn  (pFilterIn),
    .pOutValid  (pOutValid),
    .pOutReady  (pOutReady),
    .pFilterOut (pFilterOut)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the prototype filter evaluated directly on a sample history
  function automatic void model_clear();
    for (int i = 0; i < 6; i++) hist[i] = 0;
  endfunction

  function automatic void model_push(input int s);
    for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
  endfunction

  function automatic int model_phase(input bit odd);
    longint acc;
    if (!odd)
      acc = 64'sd5725 * longint'(hist[0] + hist[5]) + 64'sd5972 * longint'(hist[1] + hist[4])
          + 64'sd6098 * longint'(hist[2] + hist[3]);
    else
      acc = 64'sd5864 * longint'(hist[0] + hist[4]) + 64'sd6051 * longint'(hist[1] + hist[3])
          + 64'sd6114 * longint'(hist[2]);
`ifdef STEP_FIR_INTERP_ROUND_EN
    acc = acc + 64'sd32768;
`endif
    return int'(acc >>> 16);
  endfunction

  function automatic int sout();
    return int'($signed(pFilterOut));
  endfunction

  task automatic do_reset();
    pRst = 1'b1;
    pInValid = 1'b0;
    pOutReady = 1'b1;
    @(negedge pClk);
    pRst = 1'b0;
    model_clear();
  endtask

  // Offer one sample and collect the even/odd pair, optionally with random backpressure
  task automatic do_sample(input int s, input bit rand_bp, output int ev, output int od,
                           output bit timeout);
    int n;
    int got;
    timeout = 1'b0;
    ev = 0;
    od = 0;
    n = 0;
    while (!pInReady && n < 50) begin
      @(negedge pClk);
      n++;
    end
    pInValid  = 1'b1;
    pFilterIn = 16'(s);
    @(negedge pClk);
    pInValid  = 1'b0;
    pFilterIn = 16'($urandom);
    got = 0;
    n = 0;
    while (got < 2 && n < 300) begin
      pOutReady = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pOutValid && pOutReady) begin
        if (got == 0) ev = sout();
        else          od = sout();
        got++;
      end
      @(negedge pClk);
      n++;
    end
    pOutReady = 1'b1;
    if (got < 2) timeout = 1'b1;
  endtask

  task automatic run_vecs(input int lo, input int hi, input bit allow_rst);
    int ev, od;
    bit to;
    for (int i = lo; i <= hi; i++) begin
      if (allow_rst && vecs[i].rst) do_reset();
      model_push(vecs[i].din);
      do_sample(vecs[i].din, 1'b0, ev, od, to);
      check($sformatf("vec%0d_timeout", i), int'(to), 0);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_even", i), ev, vecs[i].ev);
        check($sformatf("vec%0d_odd", i), od, vecs[i].od);
      end
    end
  endtask

  function automatic void set_vec(input int i, input bit rst, input int din, input bit chk,
                                  input int ev, input int od);
    vecs[i].rst = rst;
    vecs[i].din = din;
    vecs[i].chk = chk;
    vecs[i].ev  = ev;
    vecs[i].od  = od;
  endfunction

  initial begin
    int imp_e [6];
    int imp_o [6];
    int dc_p_e, dc_p_o, dc_n_e, dc_n_o;
    int lat, hold, ev, od, n;
    bit to;

`ifdef STEP_FIR_INTERP_ROUND_EN
    imp_e = '{1431, 1493, 1525, 1525, 1493, 1431};
    imp_o = '{1466, 1513, 1529, 1513, 1466, 0};
    dc_p_e = 543;  dc_p_o = 457;  dc_n_e = -543; dc_n_o = -457;
`else
    imp_e = '{1431, 1493, 1524, 1524, 1493, 1431};
    imp_o = '{1466, 1512, 1528, 1512, 1466, 0};
    dc_p_e = 543;  dc_p_o = 456;  dc_n_e = -544; dc_n_o = -457;
`endif
    for (int i = 0; i < 6; i++)
      set_vec(i, i == 0, (i == 0) ? 16384 : 0, 1'b1, imp_e[i], imp_o[i]);
    for (int i = 0; i < 8; i++)
      set_vec(6 + i, i == 0, 1000, i >= 5, dc_p_e, dc_p_o);
    for (int i = 0; i < 8; i++)
      set_vec(14 + i, 1'b0, -1000, i >= 5, dc_n_e, dc_n_o);

    pRst = 1'b1;
    pInValid = 1'b0;
    pFilterIn = '0;
    pOutReady = 1'b1;
    repeat (2) @(negedge pClk);
    pRst = 1'b0;
    model_clear();
    check("rst_in_ready", int'(pInReady), 1);
    check("rst_out_valid", int'(pOutValid), 0);
    check("rst_out_data", sout(), 0);

    // First-output latency
    model_push(16384);
    pInValid = 1'b1;
    pFilterIn = 16'(16384);
    @(negedge pClk);
    pInValid = 1'b0;
    check("busy_in_ready", int'(pInReady), 0);
    lat = 1;
    while (!pOutValid && lat < 20) begin
      @(negedge pClk);
      lat++;
    end
    check("latency", lat, 4);
    check("lat_even", sout(), model_phase(1'b0));
    @(negedge pClk);
    check("lat_odd_valid", int'(pOutValid), 1);
    check("lat_odd", sout(), model_phase(1'b1));
    @(negedge pClk);
    check("lat_idle_valid", int'(pOutValid), 0);
    check("lat_idle_ready", int'(pInReady), 1);

    // Impulse and DC vectors
    run_vecs(0, 21, 1'b1);

    // Backpressure in OUT_EVEN with ignored input pulses
    model_push(777);
    pOutReady = 1'b0;
    pInValid = 1'b1;
    pFilterIn = 16'(777);
    @(negedge pClk);
    pInValid = 1'b0;
    n = 0;
    while (!pOutValid && n < 20) begin
      @(negedge pClk);
      n++;
    end
    check("bp_reach_even", int'(pOutValid), 1);
    hold = sout();
    check("bp_even", hold, model_phase(1'b0));
    for (int i = 0; i < 10; i++) begin
      pInValid = 1'($urandom_range(0, 1));
      pFilterIn = 16'($urandom);
      @(negedge pClk);
      check($sformatf("bp_hold%0d", i), sout(), hold);
      check($sformatf("bp_valid%0d", i), int'(pOutValid), 1);
      check($sformatf("bp_in_ready%0d", i), int'(pInReady), 0);
    end
    pInValid = 1'b0;
    pOutReady = 1'b1;
    @(negedge pClk);
    check("bp_odd", sout(), model_phase(1'b1));
    @(negedge pClk);
    model_push(-3210);
    do_sample(-3210, 1'b0, ev, od, to);
    check("bp_after_timeout", int'(to), 0);
    check("bp_after_even", ev, model_phase(1'b0));
    check("bp_after_odd", od, model_phase(1'b1));

    // Reset while in MULT
    pInValid = 1'b1;
    pFilterIn = 16'(5000);
    @(negedge pClk);
    pInValid = 1'b0;
    @(negedge pClk);
    pRst = 1'b1;
    @(negedge pClk);
    pRst = 1'b0;
    model_clear();
    check("midrst_valid", int'(pOutValid), 0);
    check("midrst_ready", int'(pInReady), 1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pClk);
      if (pOutValid) n++;
    end
    check("midrst_no_output", n, 0);
    run_vecs(0, 5, 1'b0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 150; i++) begin
      int s;
      s = int'($signed(16'($urandom)));
      model_push(s);
      do_sample(s, 1'b1, ev, od, to);
      check($sformatf("rnd%0d_timeout", i), int'(to), 0);
      check($sformatf("rnd%0d_even", i), ev, model_phase(1'b0));
      check($sformatf("rnd%0d_odd", i), od, model_phase(1'b1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
